// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text path: line geometry, character and
// line types, control-code constants and the text buffer state encoding.
package vga_pkg;

  localparam int unsigned N_CELLS  = 41;
  localparam int unsigned CURSOR_W = 6;   // holds 0..N_CELLS

  typedef logic [0:7] ascii_t;
  typedef ascii_t linea_t [0:N_CELLS-1];

  localparam ascii_t BS = 8'h08;
  localparam ascii_t CR = 8'h0D;
  localparam ascii_t FF = 8'h0C;

  typedef enum logic {
    IDLE,
    CLEAR
  } estado_buf_t;

endpackage

// File: rtl/decodificador_ascii.sv
// Combinational classifier for an incoming ASCII byte.
// Ports:
//   i_byte     : byte to classify
//   o_is_print : printable range 0x20..0x7E
//   o_is_bs    : backspace (0x08)
//   o_is_cr    : carriage return (0x0D)
//   o_is_ff    : form feed (0x0C)
module decodificador_ascii
  import vga_pkg::*;
(
  input  ascii_t i_byte,
  output logic   o_is_print,
  output logic   o_is_bs,
  output logic   o_is_cr,
  output logic   o_is_ff
);

  assign o_is_print = (i_byte >= 8'h20) && (i_byte <= 8'h7E);
  assign o_is_bs    = (i_byte == BS);
  assign o_is_cr    = (i_byte == CR);
  assign o_is_ff    = (i_byte == FF);

endmodule

// File: rtl/buffer_texto_vga.sv
// Text line buffer feeding the VGA text controller. Accepts ASCII bytes over a
// valid/ready handshake, edits a working line under a write cursor, and copies
// the working line to the display line only on frame_start (tear-free).
// The number of cells comes from vga_pkg::N_CELLS.
// Parameters:
//   WRAP  : 1 = a printable byte at a full line goes to cell 0; 0 = dropped
//   BLANK : code written by clear / backspace
// Ports:
//   i_clock_25    : pixel clock, all logic on rising edge
//   i_reset       : asynchronous, active-high
//   i_char_valid  : input byte valid
//   i_char_in     : ASCII byte
//   o_char_ready  : byte accepted this cycle when valid (high in IDLE)
//   i_clear       : one-cycle pulse, blank the line and home the cursor
//   i_frame_start : one-cycle pulse, copy working line to display line
//   o_cursor      : write index 0..N_CELLS (N_CELLS = line full)
//   o_char        : display line for the renderer
module buffer_texto_vga
  import vga_pkg::*;
#(
  parameter int unsigned WRAP  = 0,
  parameter ascii_t      BLANK = 8'h00
) (
  input  logic                i_clock_25,
  input  logic                i_reset,
  input  logic                i_char_valid,
  input  ascii_t              i_char_in,
  output logic                o_char_ready,
  input  logic                i_clear,
  input  logic                i_frame_start,
  output logic [CURSOR_W-1:0] o_cursor,
  output linea_t              o_char
);

  localparam logic [CURSOR_W-1:0] LAST_IDX = CURSOR_W'(N_CELLS - 1);
  localparam logic [CURSOR_W-1:0] FULL_IDX = CURSOR_W'(N_CELLS);

  estado_buf_t         r_state;
  estado_buf_t         w_state_nxt;
  logic [CURSOR_W-1:0] r_cursor;
  logic [CURSOR_W-1:0] r_idx;
  linea_t              r_work;
  linea_t              r_disp;

  logic w_accept;
  logic w_start_clear;
  logic w_is_print;
  logic w_is_bs;
  logic w_is_cr;
  logic w_is_ff;

  decodificador_ascii u_dec (
    .i_byte     (i_char_in),
    .o_is_print (w_is_print),
    .o_is_bs    (w_is_bs),
    .o_is_cr    (w_is_cr),
    .o_is_ff    (w_is_ff)
  );

  assign o_char_ready  = (r_state == IDLE);
  assign w_accept      = i_char_valid && o_char_ready;
  // A clear pulse takes priority; a byte accepted on the same edge is consumed
  // and discarded.
  assign w_start_clear = i_clear || (w_accept && w_is_ff);

  always_ff @(posedge i_clock_25 or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start_clear) w_state_nxt = CLEAR;
      CLEAR:   if (!i_clear && (r_idx == LAST_IDX)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock_25 or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < N_CELLS; i++) begin
        r_work[i] <= BLANK;
        r_disp[i] <= BLANK;
      end
      r_cursor <= '0;
      r_idx    <= '0;
    end else begin
      // Copy samples the working line before this edge's edits.
      if (i_frame_start) begin
        for (int unsigned i = 0; i < N_CELLS; i++) r_disp[i] <= r_work[i];
      end

      unique case (r_state)
        IDLE: begin
          if (w_start_clear) begin
            r_idx    <= '0;
            r_cursor <= '0;
          end else if (w_accept) begin
            if (w_is_print) begin
              if (r_cursor < FULL_IDX) begin
                r_work[r_cursor] <= i_char_in;
                r_cursor         <= r_cursor + 1'b1;
              end else if (WRAP != 0) begin
                r_work[0] <= i_char_in;
                r_cursor  <= CURSOR_W'(1);
              end
            end else if (w_is_bs) begin
              if (r_cursor != '0) begin
                r_work[r_cursor - 1'b1] <= BLANK;
                r_cursor                <= r_cursor - 1'b1;
              end
            end else if (w_is_cr) begin
              r_cursor <= '0;
            end
          end
        end
        CLEAR: begin
          r_work[r_idx] <= BLANK;
          if (i_clear) r_idx <= '0;
          else         r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_cursor = r_cursor;
  assign o_char   = r_disp;

endmodule
